// File: rtl/shared_mem_arbiter.sv
// Purpose : round-robin arbitrated single-ported data memory shared by port_count cores,
//           plus per-core sticky completion latches and a contention counter.
// Latency : grant is combinational in the request cycle; write lands on the edge ending
//           the grant cycle; read data/rvalid appear one cycle after the grant cycle.
// Backpressure: a core that is not granted keeps req asserted and retries; a grant is the
//           only acceptance signal and at most one access is served per cycle.
//
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   req/wr/addr/wdata     - per-port request, write enable, packed address and write data
//   core_done, done_clr   - per-core completion indication, synchronous latch clear
//   gnt                   - one-hot (or zero) combinational grant
//   rvalid/rdata          - registered read-return pulse and packed held read data
//   all_done              - registered AND of the completion latches
//   conflict_count        - registered saturating count of cycles with >= 2 requests
module shared_mem_arbiter #(
    parameter int port_count = 2,
    parameter int mem_width  = 12,
    parameter int addr_width = 12,
    parameter int cnt_width  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [port_count-1:0]            req,
    input  logic [port_count-1:0]            wr,
    input  logic [port_count*addr_width-1:0] addr,
    input  logic [port_count*mem_width-1:0]  wdata,
    input  logic [port_count-1:0]            core_done,
    input  logic                             done_clr,
    output logic [port_count-1:0]            gnt,
    output logic [port_count-1:0]            rvalid,
    output logic [port_count*mem_width-1:0]  rdata,
    output logic                             all_done,
    output logic [cnt_width-1:0]             conflict_count
);

    localparam int PTR_W = (port_count > 1) ? $clog2(port_count) : 1;
    localparam int DEPTH = 1 << addr_width;
    localparam logic [cnt_width-1:0] CNT_MAX = '1;

    // Advance a port index by off positions, wrapping modulo port_count.
    // off never exceeds port_count, so one subtraction is enough.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= port_count) begin
            s = s - port_count;
        end
        return PTR_W'(s);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  gnt_vld;
    logic [PTR_W-1:0]      win_idx;
    logic [port_count-1:0] gnt_d;

    always_comb begin
        gnt_vld = 1'b0;
        win_idx = '0;
        gnt_d   = '0;
        // Search upward from the pointer; the first requester found wins.
        for (int k = 0; k < port_count; k++) begin
            if (!gnt_vld && req[wrap_idx(rr_ptr_q, k)]) begin
                gnt_vld = 1'b1;
                win_idx = wrap_idx(rr_ptr_q, k);
            end
        end
        // Gating the grant with reset also blocks any memory write while in reset.
        if (!reset) begin
            gnt_vld = 1'b0;
        end
        if (gnt_vld) begin
            gnt_d[win_idx] = 1'b1;
        end
    end

    assign gnt = gnt_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = wrap_idx(win_idx, 1);
        end
    end

    // Winning port's access fields.
    logic                  sel_wr;
    logic [addr_width-1:0] sel_addr;
    logic [mem_width-1:0]  sel_wdata;

    always_comb begin
        sel_wr    = wr[win_idx];
        sel_addr  = addr[int'(win_idx)*addr_width +: addr_width];
        sel_wdata = wdata[int'(win_idx)*mem_width +: mem_width];
    end

    // ------------------------------------------------------------------
    // Storage: not reset, contents undefined until written.
    // ------------------------------------------------------------------
    logic [mem_width-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (gnt_vld && sel_wr) begin
            mem_q[sel_addr] <= sel_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read return: rdata per port holds until that port's next read.
    // ------------------------------------------------------------------
    logic [port_count-1:0] rvalid_q, rvalid_d;
    logic [mem_width-1:0]  rdata_q [port_count];

    always_comb begin
        rvalid_d = '0;
        if (gnt_vld && !sel_wr) begin
            rvalid_d[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q <= '0;
            for (int p = 0; p < port_count; p++) begin
                rdata_q[p] <= '0;
            end
        end else begin
            rvalid_q <= rvalid_d;
            if (gnt_vld && !sel_wr) begin
                rdata_q[win_idx] <= mem_q[sel_addr];
            end
        end
    end

    assign rvalid = rvalid_q;

    for (genvar p = 0; p < port_count; p++) begin : g_rdata
        assign rdata[p*mem_width +: mem_width] = rdata_q[p];
    end

    // ------------------------------------------------------------------
    // Contention counter (saturating).
    // ------------------------------------------------------------------
    logic [cnt_width-1:0] conflict_q, conflict_d;
    logic                 multi_req;

    always_comb begin
        multi_req  = ($countones(req) >= 2);
        conflict_d = conflict_q;
        if (multi_req && (conflict_q != CNT_MAX)) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    assign conflict_count = conflict_q;

    // ------------------------------------------------------------------
    // Completion latches. all_done registers the AND of the latches' next
    // state so it rises on the same edge that captures the last core_done.
    // ------------------------------------------------------------------
    logic [port_count-1:0] done_l_q, done_l_d;
    logic                  all_done_q, all_done_d;

    always_comb begin
        done_l_d = done_l_q | core_done;
        if (done_clr) begin
            done_l_d = '0;
        end
        all_done_d = &done_l_d;
    end

    assign all_done = all_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            conflict_q <= '0;
            done_l_q   <= '0;
            all_done_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            conflict_q <= conflict_d;
            done_l_q   <= done_l_d;
            all_done_q <= all_done_d;
        end
    end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Parametrised shared data memory with a round-robin arbiter that lets `port_count` processor cores share one single-ported data memory array through a request/grant handshake. It sits between the core array and data storage in the multicore processor top, replacing the fixed two-port, conflict-unaware RAM. It also latches per-core completion and raises a global end-of-operation flag.

## Interface
Parameters:
- `port_count`, 2: number of core ports, from 1 to 8.
- `mem_width`, 12: data word width.
- `addr_width`, 12: address width. Memory depth is 2^`addr_width` words.
- `cnt_width`, 16: width of the conflict counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req`  in  `port_count`: per-port access request. The core holds it until it sees `gnt`.
- `wr`  in  `port_count`: per-port write enable. 1 = write, 0 = read. Valid while `req` is high.
- `addr`  in  `port_count*addr_width`: packed addresses. Port i occupies bits [i*addr_width +: addr_width].
- `wdata`  in  `port_count*mem_width`: packed write data, packed the same way.
- `core_done`  in  `port_count`: per-core end-of-program indication (level or pulse).
- `done_clr`  in  1: synchronous clear of the completion latches.
- `gnt`  out  `port_count`: one-hot or zero combinational grant.
- `rvalid`  out  `port_count`: registered; one-cycle pulse when read data is returned.
- `rdata`  out  `port_count*mem_width`: registered, packed read data per port.
- `all_done`  out  1: registered; high when every core has reported done.
- `conflict_count`  out  `cnt_width`: registered, saturating count of contention cycles.

## Operation
Arbitration:
- Round-robin pointer `rr_ptr` with range 0..`port_count`-1.
- Each cycle the winner is the first port with `req` high, searching upward from `rr_ptr` and wrapping modulo `port_count`.
- `gnt[winner]` = 1. All other `gnt` bits = 0. If no request, `gnt` = 0.
- On any grant, `rr_ptr` becomes winner+1, wrapping to 0 after `port_count`-1. With no grant, `rr_ptr` holds.

Memory access for the granted port:
- Write: `mem[addr_i]` is updated with `wdata_i` at the edge ending the grant cycle.
- Read: `rdata_i` is loaded from `mem[addr_i]` at that edge and `rvalid[i]` is 1 for the following cycle.
- `rdata_i` holds its value until the next read granted to port i.
- Non-granted ports keep `req` asserted and retry. Their `rdata` and `rvalid` are unaffected.

Conflicts:
- A cycle where popcount(`req`) ≥ 2 increments `conflict_count` by 1.
- The counter saturates at 2^`cnt_width`-1.

Completion:
- Sticky bit `done_l[i]` is set whenever `core_done[i]` = 1.
- `all_done` is the registered AND of all `done_l` bits.
- `done_clr` clears every `done_l` bit and `all_done` on the next edge. If `done_clr` and `core_done[i]` are both high in the same cycle, the clear wins.

Memory contents:
- Memory contents are not reset and are not initialised by this block.

## Timing
- Grant latency: `gnt` is combinational in the same cycle as `req`. No wait is added when uncontended.
- Write latency: 1 edge.
- Read latency: `rvalid` and `rdata` appear 1 cycle after the grant cycle.
- Ordering: accesses are fully serialised, at most one per cycle. A read granted in cycle T+1 returns data written in cycle T.
- Reset values: `rr_ptr` = 0, `rvalid` = 0, `rdata` = 0, `conflict_count` = 0, `done_l` = 0, `all_done` = 0.
- `gnt` is forced to 0 while `reset` is low.
- Reset asserted mid-operation:
  - Registered outputs clear immediately, asynchronously.
  - A pending read's `rvalid` is dropped and the data is discarded.
  - No write occurs on any edge while `reset` is low.
- Reset release: the first grant goes to the lowest-index requesting port.
- `port_count` = 1: the port is granted every cycle `req` is high and `conflict_count` stays 0.

## Test plan
- Single port write then read:
  - Port 0 writes `addr`=0x010, `wdata`=0xABC; next cycle port 0 reads 0x010.
  - Required: `gnt[0]` in both cycles, then `rvalid[0]`=1 with `rdata0`=0xABC one cycle after the read.
- Contention, round-robin:
  - Ports 0 and 1 both read continuously for 4 cycles after reset.
  - Required: grants go 0,1,0,1 and `conflict_count`=4.
  - Each port gets `rvalid` every other cycle.
- Cross-port coherence:
  - Port 1 writes 0x055←0x123 in cycle T; port 0 reads 0x055 in T+1.
  - Required: `rdata0`=0x123 at T+2.
- Completion:
  - Pulse `core_done[0]`, then 5 cycles later pulse `core_done[1]`.
  - Required: `all_done` rises one cycle after the second pulse.
  - `done_clr` drops `all_done` to 0 on the next edge.
- Saturation:
  - With `cnt_width`=4, hold both requests for 20 cycles.
  - Required: `conflict_count` stops at 15.
- Reset mid-read:
  - Assert `reset` low in the cycle `rvalid[1]` is due.
  - Required: `rvalid`=0, `rdata`=0, `all_done`=0 immediately; a write granted in the same cycle does not change memory.
  - After release, port 0 wins first under contention.
